// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle load/store core.
package cpu_pkg;
    localparam int CPU_AW   = 32;
    localparam int CPU_DW   = 32;
    localparam int CPU_NREG = 16;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0, OP_ADD   = 4'h1, OP_SUB   = 4'h2, OP_AND   = 4'h3,
        OP_OR    = 4'h4, OP_XOR   = 4'h5, OP_ADDI  = 4'h6, OP_LUI   = 4'h7,
        OP_LD    = 4'h8, OP_ST    = 4'h9, OP_BEQ   = 4'hA, OP_JAL   = 4'hB,
        OP_RSV_C = 4'hC, OP_RSV_D = 4'hD, OP_RSV_E = 4'hE, OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {BOOT, FETCH, EXEC, MEM, HALT} state_t;
endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Entry 0 is hardwired to zero; a write in the same cycle as a read returns the old value.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int NREG = CPU_NREG,
    parameter int DW   = CPU_DW,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] raddr_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          wen,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata
);
    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wen && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/cpu_core.sv
// Multi-cycle load/store CPU, single Wishbone classic master shared by fetch and data.
// Bus outputs are registered; an access holds until ACK_I and is followed by an idle cycle.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int AW   = CPU_AW,
    parameter int DW   = CPU_DW,
    parameter int NREG = CPU_NREG
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [AW-1:0] ADR_I,
    output logic [AW-1:0] ADR_O,
    input  logic [DW-1:0] DAT_I,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I,
    output logic          HALT_O
);
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    opcode_t       op;
    logic [3:0]    rd, rs1, rs2;
    logic [DW-1:0] imm_sx, rs1_val, rs2_val, alu_res, wr_dat;
    logic [AW-1:0] pc_plus4, next_pc, ea;
    logic          alu_wen, ld_done, rf_wen;

    assign op       = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd       = ir[RD_MSB:RD_LSB];
    assign rs1      = ir[RS1_MSB:RS1_LSB];
    assign rs2      = ir[RS2_MSB:RS2_LSB];
    assign imm_sx   = {{(DW-16){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    assign pc_plus4 = pc + AW'(4);
    assign ea       = AW'(rs1_val + imm_sx);

    always_comb begin
        alu_res = '0;
        alu_wen = 1'b0;
        next_pc = pc_plus4;
        case (op)
            OP_ADD:  begin alu_res = rs1_val + rs2_val; alu_wen = 1'b1; end
            OP_SUB:  begin alu_res = rs1_val - rs2_val; alu_wen = 1'b1; end
            OP_AND:  begin alu_res = rs1_val & rs2_val; alu_wen = 1'b1; end
            OP_OR:   begin alu_res = rs1_val | rs2_val; alu_wen = 1'b1; end
            OP_XOR:  begin alu_res = rs1_val ^ rs2_val; alu_wen = 1'b1; end
            OP_ADDI: begin alu_res = rs1_val + imm_sx;  alu_wen = 1'b1; end
            OP_LUI:  begin alu_res = {ir[IMM_MSB:IMM_LSB], {(DW-16){1'b0}}}; alu_wen = 1'b1; end
            OP_BEQ:  if (rs1_val == rs2_val) next_pc = pc_plus4 + AW'(imm_sx << 2);
            OP_JAL:  begin alu_res = DW'(pc_plus4); alu_wen = 1'b1; next_pc = ea & WORD_MASK; end
            default: ;
        endcase
    end

    // Load data returns in MEM; everything else writes back in EXEC.
    assign ld_done = (state == MEM) && CYC_O && ACK_I && !WE_O;
    assign rf_wen  = ld_done || ((state == EXEC) && alu_wen);
    assign wr_dat  = ld_done ? DAT_I : alu_res;
    assign STB_O   = CYC_O;

    cpu_regfile #(.NREG(NREG), .DW(DW)) u_regfile (
        .clk     (CLK_I),
        .rst_n   (RST_I),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rs1_val),
        .rdata_b (rs2_val),
        .wen     (rf_wen),
        .waddr   (rd),
        .wdata   (wr_dat)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state  <= BOOT;
            pc     <= '0;
            ir     <= '0;
            ADR_O  <= '0;
            DAT_O  <= '0;
            CYC_O  <= 1'b0;
            WE_O   <= 1'b0;
            HALT_O <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    pc    <= ADR_I & WORD_MASK;
                    ADR_O <= ADR_I & WORD_MASK;
                    CYC_O <= 1'b1;
                    state <= FETCH;
                end
                FETCH: begin
                    // Entered idle after a data access: this cycle is the mandatory gap.
                    if (!CYC_O) begin
                        CYC_O <= 1'b1;
                        ADR_O <= pc;
                    end else if (ACK_I) begin
                        ir    <= DAT_I;
                        CYC_O <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (op == OP_HALT) begin
                        HALT_O <= 1'b1;
                        state  <= HALT;
                    end else if (op == OP_LD || op == OP_ST) begin
                        pc    <= pc_plus4;
                        ADR_O <= ea & WORD_MASK;
                        WE_O  <= (op == OP_ST);
                        if (op == OP_ST) DAT_O <= rs2_val;
                        CYC_O <= 1'b1;
                        state <= MEM;
                    end else begin
                        pc    <= next_pc;
                        ADR_O <= next_pc;
                        CYC_O <= 1'b1;
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (ACK_I) begin
                        CYC_O <= 1'b0;
                        WE_O  <= 1'b0;
                        state <= FETCH;
                    end
                end
                HALT:    ;
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a word-addressed memory slave with programmable wait states
// plus a bus monitor; each scenario task runs a small program and checks the bus traffic.
module tb_cpu_core;
    import cpu_pkg::*;

    logic        CLK_I, RST_I, CYC_O, STB_O, WE_O, ACK_I, HALT_O;
    logic [31:0] ADR_I, ADR_O, DAT_I, DAT_O;

    cpu_core dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .ADR_O(ADR_O), .DAT_I(DAT_I),
        .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
        .HALT_O(HALT_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    int          wait_n = 0, wcnt = 0, acks = 0, starts = 0, stab_err = 0, gap_err = 0;
    logic        spur = 1'b0, prev_cyc = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_adr = '0, prev_dat = '0;
    logic [31:0] rd_q[$], wr_adr_q[$], wr_dat_q[$];
    logic [31:0] exp_adr[10], exp_dat[10];

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
    endfunction

    // Memory slave and bus-rule monitor, driven away from the rising edge.
    initial begin
        ACK_I = 1'b0;
        DAT_I = 32'hDEAD_BEEF;
        forever begin
            @(negedge CLK_I);
            if (ACK_I && CYC_O) gap_err++;
            if (CYC_O) begin
                if (!prev_cyc) starts++;
                else if (ADR_O !== prev_adr || WE_O !== prev_we || DAT_O !== prev_dat) stab_err++;
                if (STB_O !== 1'b1 || ADR_O[1:0] !== 2'b00) stab_err++;
            end
            prev_cyc = CYC_O; prev_adr = ADR_O; prev_we = WE_O; prev_dat = DAT_O;
            ACK_I = 1'b0;
            DAT_I = 32'hDEAD_BEEF;
            if (!CYC_O) begin
                wcnt  = 0;
                ACK_I = spur;
            end else if (wcnt < wait_n) begin
                wcnt++;
            end else begin
                ACK_I = 1'b1;
                wcnt  = 0;
                acks++;
                if (WE_O) begin
                    mem[ADR_O[9:2]] = DAT_O;
                    wr_adr_q.push_back(ADR_O);
                    wr_dat_q.push_back(DAT_O);
                end else begin
                    DAT_I = mem[ADR_O[9:2]];
                    rd_q.push_back(ADR_O);
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000;
    endtask

    task automatic boot(input logic [31:0] vec);
        @(negedge CLK_I);
        RST_I = 1'b0;
        ADR_I = vec;
        repeat (2) @(negedge CLK_I);
        rd_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
        acks = 0; starts = 0; stab_err = 0; gap_err = 0;
        RST_I = 1'b1;
    endtask

    task automatic wait_halt(input string name, output int n);
        n = 0;
        while (HALT_O !== 1'b1 && n < 3000) begin @(negedge CLK_I); n++; end
        vectors++;
        if (HALT_O !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_halt: HALT_O=%b after %0d cycles, expected 1", name, HALT_O, n);
        end
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[64] = enc(OP_LUI, 1, 0, 0, 16'h1234);
        mem[65] = enc(OP_ADDI, 1, 1, 0, 16'h5678);
        mem[66] = enc(OP_ADDI, 2, 0, 0, -1);
        mem[67] = enc(OP_ADD, 3, 1, 2, 0);
        mem[68] = enc(OP_ST, 0, 0, 3, 16'h40);
        mem[69] = enc(OP_LD, 4, 0, 0, 16'h40);
        mem[70] = enc(OP_ST, 0, 0, 4, 16'h44);
        mem[71] = enc(OP_LUI, 8, 0, 0, 16'hF0F0);
        mem[72] = enc(OP_SUB, 5, 3, 1, 0);
        mem[73] = enc(OP_AND, 6, 1, 8, 0);
        mem[74] = enc(OP_OR, 7, 8, 1, 0);
        mem[75] = enc(OP_XOR, 9, 8, 1, 0);
        mem[76] = enc(OP_ST, 0, 0, 5, 16'h48);
        mem[77] = enc(OP_ST, 0, 0, 6, 16'h4C);
        mem[78] = enc(OP_ST, 0, 0, 7, 16'h50);
        mem[79] = enc(OP_ST, 0, 0, 9, 16'h54);
        mem[80] = enc(OP_ADDI, 0, 0, 0, 5);
        mem[81] = enc(OP_ST, 0, 0, 0, 16'h58);
        mem[82] = enc(OP_ADDI, 10, 0, 0, 16'h80);
        mem[83] = enc(OP_ST, 0, 10, 1, -4);
        mem[84] = enc(OP_ST, 0, 0, 1, 16'h5E);
        mem[85] = enc(OP_ADDI, 11, 0, 0, 3);
        mem[86] = enc(OP_ADD, 11, 11, 11, 0);
        mem[87] = enc(OP_ST, 0, 0, 11, 16'h60);
        exp_adr = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h7C, 32'h5C, 32'h60};
        exp_dat = '{32'h1234_5677, 32'h1234_5677, 32'hFFFF_FFFF, 32'h1030_0000, 32'hF2F4_5678,
                    32'hE2C4_5678, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0006};
    endtask

    task automatic test_reset();
        int n;
        clear_mem();
        RST_I = 1'b0; ADR_I = 32'h100;
        repeat (2) @(negedge CLK_I);
        vectors++; if (CYC_O !== 1'b0) begin miscompares++; $display("FAIL rst_cyc: got %b, expected 0", CYC_O); end
        vectors++; if (STB_O !== 1'b0) begin miscompares++; $display("FAIL rst_stb: got %b, expected 0", STB_O); end
        vectors++; if (WE_O !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b, expected 0", WE_O); end
        vectors++; if (HALT_O !== 1'b0) begin miscompares++; $display("FAIL rst_halt: got %b, expected 0", HALT_O); end
        vectors++; if (ADR_O !== 32'h0) begin miscompares++; $display("FAIL rst_adr: got %h, expected 0", ADR_O); end
        vectors++; if (DAT_O !== 32'h0) begin miscompares++; $display("FAIL rst_dat: got %h, expected 0", DAT_O); end
        RST_I = 1'b1;
        @(negedge CLK_I);
        vectors++; if (CYC_O !== 1'b1) begin miscompares++; $display("FAIL boot_cyc: got %b, expected 1", CYC_O); end
        vectors++; if (ADR_O !== 32'h100) begin miscompares++; $display("FAIL boot_adr: got %h, expected 00000100", ADR_O); end
        vectors++; if (WE_O !== 1'b0) begin miscompares++; $display("FAIL boot_we: got %b, expected 0", WE_O); end
        n = 1;
        while (HALT_O !== 1'b1 && n < 100) begin @(negedge CLK_I); n++; end
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL boot_halt_latency: got %0d cycles, expected 3", n); end
    endtask

    task automatic test_alu_mem();
        int n;
        load_prog_a();
        wait_n = 0;
        boot(32'h100);
        wait_halt("alu_mem", n);
        vectors++;
        if (wr_adr_q.size() !== 10) begin miscompares++; $display("FAIL alu_mem_nwr: got %0d, expected 10", wr_adr_q.size()); end
        for (int i = 0; i < 10 && i < wr_adr_q.size(); i++) begin
            vectors++;
            if (wr_adr_q[i] !== exp_adr[i]) begin miscompares++; $display("FAIL alu_mem_wadr[%0d]: got %h, expected %h", i, wr_adr_q[i], exp_adr[i]); end
            vectors++;
            if (wr_dat_q[i] !== exp_dat[i]) begin miscompares++; $display("FAIL alu_mem_wdat[%0d]: got %h, expected %h", i, wr_dat_q[i], exp_dat[i]); end
        end
        vectors++; if (acks !== 36) begin miscompares++; $display("FAIL alu_mem_acks: got %0d, expected 36", acks); end
        vectors++; if (gap_err !== 0) begin miscompares++; $display("FAIL alu_mem_gap: got %0d violations, expected 0", gap_err); end
    endtask

    task automatic test_wait_states();
        int n;
        load_prog_a();
        wait_n = 3;
        boot(32'h100);
        wait_halt("wait", n);
        vectors++;
        if (wr_adr_q.size() !== 10) begin miscompares++; $display("FAIL wait_nwr: got %0d, expected 10", wr_adr_q.size()); end
        for (int i = 0; i < 10 && i < wr_adr_q.size(); i++) begin
            vectors++;
            if (wr_adr_q[i] !== exp_adr[i] || wr_dat_q[i] !== exp_dat[i]) begin
                miscompares++;
                $display("FAIL wait_wr[%0d]: got %h=%h, expected %h=%h", i, wr_adr_q[i], wr_dat_q[i], exp_adr[i], exp_dat[i]);
            end
        end
        vectors++; if (acks !== 36) begin miscompares++; $display("FAIL wait_acks: got %0d, expected 36", acks); end
        vectors++; if (starts !== acks) begin miscompares++; $display("FAIL wait_single: got %0d cycles for %0d acks, expected equal", starts, acks); end
        vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL wait_stable: got %0d changes, expected 0", stab_err); end
        vectors++; if (gap_err !== 0) begin miscompares++; $display("FAIL wait_gap: got %0d violations, expected 0", gap_err); end
        wait_n = 0;
    endtask

    task automatic test_control();
        int n;
        logic [31:0] exp_rd[11];
        clear_mem();
        mem[64]  = enc(OP_BEQ, 0, 0, 0, 2);
        mem[67]  = enc(OP_ADDI, 1, 0, 0, 7);
        mem[68]  = enc(OP_BEQ, 0, 1, 0, 5);
        mem[69]  = enc(OP_JAL, 5, 0, 0, 16'h200);
        mem[128] = enc(OP_ST, 0, 0, 5, 16'h40);
        mem[129] = enc(OP_ADDI, 2, 0, 0, 16'h210);
        mem[130] = enc(OP_JAL, 7, 2, 0, 2);
        mem[132] = enc(OP_ST, 0, 0, 7, 16'h44);
        mem[133] = enc(4'hD, 3, 3, 3, 16'h1111);
        mem[134] = enc(OP_NOP, 0, 0, 0, 0);
        exp_rd = '{32'h100, 32'h10C, 32'h110, 32'h114, 32'h200, 32'h204, 32'h208,
                   32'h210, 32'h214, 32'h218, 32'h21C};
        boot(32'h100);
        wait_halt("control", n);
        vectors++;
        if (rd_q.size() !== 11) begin miscompares++; $display("FAIL ctl_nfetch: got %0d, expected 11", rd_q.size()); end
        for (int i = 0; i < 11 && i < rd_q.size(); i++) begin
            vectors++;
            if (rd_q[i] !== exp_rd[i]) begin miscompares++; $display("FAIL ctl_fetch[%0d]: got %h, expected %h", i, rd_q[i], exp_rd[i]); end
        end
        vectors++;
        if (wr_adr_q.size() !== 2) begin
            miscompares++; $display("FAIL ctl_nwr: got %0d, expected 2", wr_adr_q.size());
        end else begin
            vectors++;
            if (wr_adr_q[0] !== 32'h40 || wr_dat_q[0] !== 32'h118) begin
                miscompares++; $display("FAIL ctl_jal_link: got %h=%h, expected 00000040=00000118", wr_adr_q[0], wr_dat_q[0]);
            end
            vectors++;
            if (wr_adr_q[1] !== 32'h44 || wr_dat_q[1] !== 32'h20C) begin
                miscompares++; $display("FAIL ctl_jalr_link: got %h=%h, expected 00000044=0000020c", wr_adr_q[1], wr_dat_q[1]);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        clear_mem();
        mem[255] = enc(OP_ADDI, 1, 0, 0, 9);
        mem[0]   = enc(OP_ST, 0, 0, 1, 16'h40);
        boot(32'hFFFF_FFFE);
        wait_halt("wrap", n);
        vectors++;
        if (rd_q.size() !== 3) begin
            miscompares++; $display("FAIL wrap_nfetch: got %0d, expected 3", rd_q.size());
        end else begin
            vectors++; if (rd_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_boot: got %h, expected fffffffc", rd_q[0]); end
            vectors++; if (rd_q[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h, expected 00000000", rd_q[1]); end
        end
        vectors++;
        if (wr_dat_q.size() !== 1 || wr_dat_q[0] !== 32'h9) begin
            miscompares++; $display("FAIL wrap_store: got %0d writes, first %h, expected 1 write of 00000009", wr_dat_q.size(), (wr_dat_q.size() > 0) ? wr_dat_q[0] : 32'hx);
        end
    endtask

    task automatic test_halt_idle();
        int busy = 0;
        int lost = 0;
        for (int i = 0; i < 20; i++) begin
            spur = (i < 5);
            @(negedge CLK_I);
            if (CYC_O !== 1'b0) busy++;
            if (HALT_O !== 1'b1) lost++;
        end
        spur = 1'b0;
        vectors++; if (busy !== 0) begin miscompares++; $display("FAIL halt_idle_cyc: got %0d busy cycles, expected 0", busy); end
        vectors++; if (lost !== 0) begin miscompares++; $display("FAIL halt_sticky: got %0d cycles not halted, expected 0", lost); end
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        clear_mem();
        wait_n = 1000;
        boot(32'h100);
        n = 0;
        while (CYC_O !== 1'b1 && n < 10) begin @(negedge CLK_I); n++; end
        repeat (5) @(negedge CLK_I);
        vectors++;
        if (CYC_O !== 1'b1 || ADR_O !== 32'h100) begin
            miscompares++; $display("FAIL stall_hold: got cyc=%b adr=%h, expected cyc=1 adr=00000100", CYC_O, ADR_O);
        end
        #2 RST_I = 1'b0;
        #1;
        vectors++; if (CYC_O !== 1'b0) begin miscompares++; $display("FAIL async_rst_cyc: got %b, expected 0", CYC_O); end
        vectors++; if (STB_O !== 1'b0) begin miscompares++; $display("FAIL async_rst_stb: got %b, expected 0", STB_O); end
        vectors++; if (ADR_O !== 32'h0) begin miscompares++; $display("FAIL async_rst_adr: got %h, expected 0", ADR_O); end
        wait_n = 0;
        boot(32'h203);
        wait_halt("reboot", n);
        vectors++;
        if (rd_q.size() !== 1 || rd_q[0] !== 32'h200) begin
            miscompares++; $display("FAIL reboot_fetch: got %0d fetches, first %h, expected 1 at 00000200", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
        end
        vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL reboot_stable: got %0d, expected 0", stab_err); end
    endtask

    initial begin
        RST_I = 1'b0;
        ADR_I = 32'h0;
        test_reset();
        test_alu_mem();
        test_wait_states();
        test_control();
        test_wrap();
        test_halt_idle();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
